// File: rtl/vending_pkg.sv
// Shared state encoding and coin table for the vending order front-end.
package vending_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    EVAL,
    DISPENSE,
    CHANGE
  } vend_state_t;

  localparam int COIN_VAL [4] = '{1, 2, 5, 10};
  localparam int MONEY_MAX    = 15;

endpackage

// File: rtl/vending_coin_acc.sv
// Credit register: decodes coin denominations, loads or adds accepted coins, and
// rejects any coin that is not allowed or would overflow the credit (reject 1 cycle after strobe).
module vending_coin_acc
  import vending_pkg::*;
#(
  parameter int MONEY_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               coin_valid,
  input  logic [1:0]         coin_val,
  input  logic               accept_en,
  input  logic               load,
  input  logic               clear,
  output logic [MONEY_W-1:0] credit,
  output logic               coin_reject
);

  logic [MONEY_W:0] coin_amt;
  logic [MONEY_W:0] sum;
  logic             take;

  // One extra bit on the sum flags a credit that would exceed the register range.
  always_comb begin
    coin_amt = (MONEY_W+1)'(COIN_VAL[coin_val]);
    sum      = (load ? {(MONEY_W+1){1'b0}} : {1'b0, credit}) + coin_amt;
    take     = coin_valid && accept_en && !sum[MONEY_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit      <= '0;
      coin_reject <= 1'b0;
    end else begin
      coin_reject <= coin_valid && !take;
      if (clear) begin
        credit <= '0;
      end else if (take) begin
        credit <= sum[MONEY_W-1:0];
      end
    end
  end

endmodule

// File: rtl/vending_order_ctrl.sv
// Order front-end for the vendingmachine price checker: collects credit, evaluates the order,
// then runs the dispense and change/refund handshakes. VEND_TIMEOUT_EN adds an idle auto-refund.
module vending_order_ctrl
  import vending_pkg::*;
#(
  parameter int CODE_W         = 2,
  parameter int COUNT_W        = 3,
  parameter int MONEY_W        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               coin_valid,
  input  logic [1:0]         coin_val,
  output logic               coin_reject,
  input  logic               sel_valid,
  input  logic [CODE_W-1:0]  sel_code,
  input  logic [COUNT_W-1:0] sel_count,
  input  logic               cancel,
  output logic [CODE_W-1:0]  vm_code,
  output logic [COUNT_W-1:0] vm_count,
  output logic [MONEY_W-1:0] vm_money,
  input  logic               vm_posibility,
  input  logic [MONEY_W-1:0] vm_remaining,
  output logic               disp_valid,
  input  logic               disp_ready,
  output logic               chg_valid,
  output logic [MONEY_W-1:0] chg_amount,
  input  logic               chg_ready,
  output logic               busy
);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  vend_state_t        state, state_nx;
  logic [MONEY_W-1:0] credit;
  logic               acc_en, acc_load, credit_clr;
  logic               latch_sel, refund_credit, take_remaining, clear_order;
  logic               timeout_hit;

  vending_coin_acc #(
    .MONEY_W (MONEY_W)
  ) u_coin_acc (
    .clk         (clk),
    .rst         (rst),
    .coin_valid  (coin_valid),
    .coin_val    (coin_val),
    .accept_en   (acc_en),
    .load        (acc_load),
    .clear       (credit_clr),
    .credit      (credit),
    .coin_reject (coin_reject)
  );

  assign vm_money   = credit;
  assign busy       = (state != IDLE);
  assign disp_valid = (state == DISPENSE);
  assign chg_valid  = (state == CHANGE);

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  logic          collect_evt;

  assign collect_evt = coin_valid || sel_valid || cancel;
  assign timeout_hit = (state == COLLECT) && !collect_evt &&
                       (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state != COLLECT || collect_evt) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nx       = state;
    acc_en         = 1'b0;
    acc_load       = 1'b0;
    credit_clr     = 1'b0;
    latch_sel      = 1'b0;
    refund_credit  = 1'b0;
    take_remaining = 1'b0;
    clear_order    = 1'b0;
    unique case (state)
      IDLE: begin
        acc_en   = 1'b1;
        acc_load = 1'b1;
        if (coin_valid) state_nx = COLLECT;
      end
      COLLECT: begin
        // Cancel blocks a same-cycle coin so the refund matches the credit exactly.
        if (cancel) begin
          refund_credit = 1'b1;
          state_nx      = CHANGE;
        end else begin
          acc_en = 1'b1;
          if (sel_valid && sel_count != '0) begin
            latch_sel = 1'b1;
            state_nx  = EVAL;
          end else if (timeout_hit) begin
            refund_credit = 1'b1;
            state_nx      = CHANGE;
          end
        end
      end
      EVAL: begin
        if (vm_posibility) begin
          take_remaining = 1'b1;
          state_nx       = DISPENSE;
        end else begin
          state_nx = COLLECT;
        end
      end
      DISPENSE: begin
        if (disp_ready) begin
          if (chg_amount != '0) begin
            state_nx = CHANGE;
          end else begin
            credit_clr = 1'b1;
            state_nx   = IDLE;
          end
        end
      end
      CHANGE: begin
        if (chg_ready) begin
          credit_clr  = 1'b1;
          clear_order = 1'b1;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vm_code    <= '0;
      vm_count   <= '0;
      chg_amount <= '0;
    end else begin
      state <= state_nx;
      if (latch_sel) begin
        vm_code  <= sel_code;
        vm_count <= sel_count;
      end else if (clear_order) begin
        vm_code  <= '0;
        vm_count <= '0;
      end
      if (refund_credit) begin
        chg_amount <= credit;
      end else if (take_remaining) begin
        chg_amount <= vm_remaining;
      end else if (clear_order) begin
        chg_amount <= '0;
      end
    end
  end

endmodule
